px_block_row_gather: RTL

- Parametrised successor of the 8x8 pixel-to-DCT adapter.
- Gathers BLK_N consecutive pixels from each of BLK_N parallel line streams in turn: line 0, then line 1, up to line BLK_N-1, then back to line 0 for the next block.
- Emits one BLK_N-pixel row word per gather, optionally level-shifted, with row index, frame/line sideband and alignment checking.
- Sits between the line buffer and the row DCT stage. A gather/output double register sustains 1 px/clk under backpressure.

---
 rtl/jpeg_enc_pkg.sv | 24 ++
 rtl/px_row_skid.sv | 53 +++++
 rtl/px_block_row_gather.sv | 111 +++++++++++
 3 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared definitions for the JPEG encoder front end: level shift,
// counter-width helper and the default row-word type.
package jpeg_enc_pkg;

  localparam int DEF_PX_WIDTH = 8;
  localparam int DEF_BLK_N    = 8;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = cnt_w(DEF_BLK_N);

  typedef logic [DEF_BLK_N-1:0][DEF_PX_WIDTH-1:0] px_row_t;

  // Subtracting 2**(w-1) modulo 2**w is the same as inverting the pixel MSB.
  function automatic logic [15:0] level_shift(input logic [15:0] px, input int px_width,
                                              input bit shift_en);
    logic [15:0] w_msb;
    w_msb = 16'(1) << (px_width - 1);
    return shift_en ? (px ^ w_msb) : px;
  endfunction

endpackage

// File: rtl/px_row_skid.sv
// Output register with a one-deep hold slot; full_o stalls the producer
// until the held word moves into the output register.
module px_row_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         full_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         r_full;
  logic         r_out_valid;
  logic [W-1:0] r_hold;
  logic [W-1:0] r_out;
  logic         w_out_free;

  assign w_out_free = !r_out_valid || out_ready_i;

  // in_valid_i never arrives while r_full, because the producer is stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
      r_hold      <= '0;
      r_out       <= '0;
    end else if (w_out_free) begin
      if (r_full) begin
        r_out       <= r_hold;
        r_out_valid <= 1'b1;
        r_full      <= 1'b0;
      end else if (in_valid_i) begin
        r_out       <= in_data_i;
        r_out_valid <= 1'b1;
      end else begin
        r_out       <= '0;
        r_out_valid <= 1'b0;
      end
    end else if (in_valid_i) begin
      r_hold <= in_data_i;
      r_full <= 1'b1;
    end
  end

  assign full_o      = r_full;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out;

endmodule

// File: rtl/px_block_row_gather.sv
// Gathers BLK_N pixels from each of BLK_N line streams in rotation and
// emits one level-shifted row word per gather to the row DCT stage.
module px_block_row_gather
  import jpeg_enc_pkg::*;
#(
  parameter int PX_WIDTH = 8,
  parameter int BLK_N    = 8,
  parameter int SHIFT_EN = 1,
  parameter int SER_W    = ((PX_WIDTH + 7) / 8) * 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [BLK_N*SER_W-1:0]     ser_tdata_i,
  input  logic [BLK_N-1:0]           ser_tvalid_i,
  output logic [BLK_N-1:0]           ser_tready_o,
  input  logic [BLK_N-1:0]           ser_tlast_i,
  input  logic [BLK_N-1:0]           ser_tuser_i,
  output logic [BLK_N*PX_WIDTH-1:0]  par_tdata_o,
  output logic                       par_tvalid_o,
  input  logic                       par_tready_i,
  output logic                       par_tlast_o,
  output logic                       par_tuser_o,
  output logic [$clog2(BLK_N)-1:0]   par_row_o,
  output logic                       align_err_o
);

  localparam int LN_W  = cnt_w(BLK_N);
  localparam int ROW_W = BLK_N * PX_WIDTH;
  localparam int PAY_W = ROW_W + 2 + LN_W;

  logic [LN_W-1:0]     r_px_cnt;
  logic [LN_W-1:0]     r_ln_cnt;
  // The final pixel of a row bypasses storage straight into the row word.
  logic [PX_WIDTH-1:0] r_gather [BLK_N-1];
  logic                r_g_last;
  logic                r_g_user;
  logic                r_align_err;

  logic                w_full;
  logic                w_acc;
  logic                w_last_px;
  logic                w_complete;
  logic                w_sel_last;
  logic                w_sel_user;
  logic [PX_WIDTH-1:0] w_sel_px;
  logic [PX_WIDTH-1:0] w_px;
  logic [ROW_W-1:0]    w_row;
  logic [PAY_W-1:0]    w_pay_in;
  logic [PAY_W-1:0]    w_pay_out;

  assign w_sel_px   = ser_tdata_i[r_ln_cnt*SER_W +: PX_WIDTH];
  assign w_sel_last = ser_tlast_i[r_ln_cnt];
  assign w_sel_user = ser_tuser_i[r_ln_cnt];
  assign w_px       = PX_WIDTH'(level_shift(16'(w_sel_px), PX_WIDTH, SHIFT_EN != 0));
  assign w_acc      = ser_tvalid_i[r_ln_cnt] && !w_full;
  assign w_last_px  = (r_px_cnt == LN_W'(BLK_N - 1));
  assign w_complete = w_acc && w_last_px;

  for (genvar gi = 0; gi < BLK_N; gi++) begin : g_lane
    assign ser_tready_o[gi] = (r_ln_cnt == LN_W'(gi)) && !w_full;
    if (gi == BLK_N - 1) begin : g_tail
      assign w_row[gi*PX_WIDTH +: PX_WIDTH] = w_px;
    end else begin : g_body
      assign w_row[gi*PX_WIDTH +: PX_WIDTH] = r_gather[gi];
    end
  end

  assign w_pay_in = {r_ln_cnt, r_g_user | w_sel_user, r_g_last | w_sel_last, w_row};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_px_cnt    <= '0;
      r_ln_cnt    <= '0;
      r_g_last    <= 1'b0;
      r_g_user    <= 1'b0;
      r_align_err <= 1'b0;
      for (int i = 0; i < BLK_N - 1; i++) r_gather[i] <= '0;
    end else if (w_acc) begin
      r_px_cnt <= r_px_cnt + LN_W'(1);
      if (w_last_px) begin
        r_ln_cnt <= r_ln_cnt + LN_W'(1);
        r_g_last <= 1'b0;
        r_g_user <= 1'b0;
      end else begin
        r_gather[r_px_cnt] <= w_px;
        r_g_last           <= r_g_last | w_sel_last;
        r_g_user           <= r_g_user | w_sel_user;
      end
      if ((w_sel_last && !w_last_px) ||
          (w_sel_user && (r_ln_cnt != '0 || r_px_cnt != '0)))
        r_align_err <= 1'b1;
    end
  end

  px_row_skid #(
    .W(PAY_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (w_complete),
    .in_data_i   (w_pay_in),
    .full_o      (w_full),
    .out_valid_o (par_tvalid_o),
    .out_ready_i (par_tready_i),
    .out_data_o  (w_pay_out)
  );

  assign {par_row_o, par_tuser_o, par_tlast_o, par_tdata_o} = w_pay_out;
  assign align_err_o = r_align_err;

endmodule
